// File: rtl/key_debounce_arbiter_pkg.sv
// Shared types and constants for the key debounce arbiter.
//   state_t              : arbiter FSM state (IDLE = timer free, COUNT = timer running)
//   DEBOUNCE_20MS_50MHZ  : default debounce window, 20 ms at a 50 MHz clock
package key_debounce_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEBOUNCE_20MS_50MHZ = 1000000;

endpackage

// File: rtl/key_debounce_arbiter_if.sv
// Key/press-event bundle between the board key pins, the arbiter and the UI logic.
//   key         : raw active-low key pins (driven by the board side)
//   press       : one-hot, one-cycle pulse per confirmed press
//   press_valid : high together with any press pulse
//   press_id    : index of the pressed key, 0 when press_valid is low
//   busy        : shared debounce timer is in use
// modport master : the arbiter (consumes key, produces events)
// modport slave  : the board/UI side
interface key_debounce_arbiter_if #(
  parameter int NUM_KEYS = 4
);
  localparam int ID_W = $clog2(NUM_KEYS);

  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] press;
  logic                press_valid;
  logic [ID_W-1:0]     press_id;
  logic                busy;

  modport master (
    input  key,
    output press, press_valid, press_id, busy
  );

  modport slave (
    output key,
    input  press, press_valid, press_id, busy
  );

endinterface

// File: rtl/key_debounce_arbiter_rr_pick.sv
// Combinational round-robin first-one finder.
//   pending : request vector
//   rr_ptr  : index searched first; search wraps modulo NUM_KEYS
//   idx     : first pending index at or after rr_ptr (0 when none)
//   any     : at least one request pending
module key_debounce_arbiter_rr_pick #(
  parameter int NUM_KEYS = 4,
  parameter int ID_W     = $clog2(NUM_KEYS)
) (
  input  logic [NUM_KEYS-1:0] pending,
  input  logic [ID_W-1:0]     rr_ptr,
  output logic [ID_W-1:0]     idx,
  output logic                any
);

  // Scan from the farthest offset back to rr_ptr so the nearest hit wins.
  always_comb begin
    idx = '0;
    any = |pending;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % NUM_KEYS]) begin
        idx = ID_W'((int'(rr_ptr) + k) % NUM_KEYS);
      end
    end
  end

endmodule

// File: rtl/key_debounce_arbiter.sv
// Debounces NUM_KEYS active-low push-buttons with a single shared timer.
// Each synchronized falling edge queues a pending request; a round-robin
// arbiter hands the timer to one key at a time and, when the window expires,
// reports the press if the key is still low.
//   clk   : system clock
//   rst_n : asynchronous, active-low reset
//   kif   : key pins in, press/press_valid/press_id/busy out (master modport)
module key_debounce_arbiter
  import key_debounce_arbiter_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int DELAY_TIME = DEBOUNCE_20MS_50MHZ
) (
  input  logic                   clk,
  input  logic                   rst_n,
  key_debounce_arbiter_if.master kif
);

  localparam int CNT_W = $clog2(DELAY_TIME);
  localparam int ID_W  = $clog2(NUM_KEYS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_TIME - 1);

  logic [NUM_KEYS-1:0] key_p0, key_p1, key_p2;
  logic [NUM_KEYS-1:0] fall;
  logic [NUM_KEYS-1:0] pending, pending_nxt;
  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ID_W-1:0]     active, active_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [NUM_KEYS-1:0] press_q, press_nxt;
  logic                press_valid_q, press_valid_nxt;
  logic [ID_W-1:0]     press_id_q, press_id_nxt;

  // Stage p0/p1: two-flop synchronizer; stage p2: history for edge detection.
  // All reset to 1 so a key held through reset still produces one fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= '1;
      key_p1 <= '1;
      key_p2 <= '1;
    end else begin
      key_p0 <= kif.key;
      key_p1 <= key_p0;
      key_p2 <= key_p1;
    end
  end

  assign fall = key_p2 & ~key_p1;

  key_debounce_arbiter_rr_pick #(
    .NUM_KEYS (NUM_KEYS),
    .ID_W     (ID_W)
  ) u_rr_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    active_nxt      = active;
    rr_ptr_nxt      = rr_ptr;
    pending_nxt     = pending | fall;
    press_nxt       = '0;
    press_valid_nxt = 1'b0;
    press_id_nxt    = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          active_nxt            = pick_idx;
          // The grant clears the request even if the same key falls again now.
          pending_nxt[pick_idx] = 1'b0;
          cnt_nxt               = '0;
          state_nxt             = COUNT;
        end
      end
      COUNT: begin
        // Further falls on the key being timed are bounce, not new requests.
        pending_nxt[active] = pending[active];
        if (cnt == CNT_LAST) begin
          if (!key_p1[active]) begin
            press_nxt[active] = 1'b1;
            press_valid_nxt   = 1'b1;
            press_id_nxt      = active;
          end
          rr_ptr_nxt = (active == ID_W'(NUM_KEYS - 1)) ? '0 : active + 1'b1;
          cnt_nxt    = '0;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbiter state and registered press outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      active        <= '0;
      rr_ptr        <= '0;
      pending       <= '0;
      press_q       <= '0;
      press_valid_q <= 1'b0;
      press_id_q    <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      active        <= active_nxt;
      rr_ptr        <= rr_ptr_nxt;
      pending       <= pending_nxt;
      press_q       <= press_nxt;
      press_valid_q <= press_valid_nxt;
      press_id_q    <= press_id_nxt;
    end
  end

  assign kif.press       = press_q;
  assign kif.press_valid = press_valid_q;
  assign kif.press_id    = press_id_q;
  assign kif.busy        = (state == COUNT);

endmodule
